// File: rtl/dna_emu_pkg.sv
// Shared constants and state type for the soft DNA_PORT responder.
package dna_emu_pkg;

  localparam int unsigned DNA_WIDTH = 57;
  localparam int unsigned CNT_W     = 6;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_WIDTH - 1);

  typedef enum logic [1:0] {
    EMPTY,
    LOADED,
    SHIFTING,
    DRAINED_ST
  } dna_state_t;

endpackage

// File: rtl/dna_port_emu.sv
// Soft DNA_PORT responder: loads a 57-bit DNA image on READ and shifts it
// out MSB-first on o_dout, with DIN entering at the LSB.
// Optional feature macro: DNA_EMU_WRITE_EN adds a valid/ready write port
// that updates a shadow copy of the image used by the next READ.
module dna_port_emu
  import dna_emu_pkg::*;
#(
  parameter logic [DNA_WIDTH-1:0] DNA_VALUE = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_read,
  input  logic                 i_shift,
  input  logic                 i_din,
`ifdef DNA_EMU_WRITE_EN
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [DNA_WIDTH-1:0] i_wr_data,
`endif
  output logic                 o_dout,
  output logic                 o_loaded,
  output logic                 o_drained,
  output logic [CNT_W-1:0]     o_shift_cnt
);

  dna_state_t           r_state;
  dna_state_t           w_state_nxt;
  logic [DNA_WIDTH-1:0] r_sr;
  logic [DNA_WIDTH-1:0] w_sr_nxt;
  logic [DNA_WIDTH-1:0] w_image;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 r_loaded;
  logic                 w_loaded_nxt;
  logic                 r_drained;
  logic                 w_drained_nxt;

`ifdef DNA_EMU_WRITE_EN
  logic [DNA_WIDTH-1:0] r_shadow;
  logic [DNA_WIDTH-1:0] w_shadow_nxt;
  logic                 r_wr_ready;
  logic                 w_wr_ready_nxt;

  assign w_image = r_shadow;
`else
  assign w_image = DNA_VALUE;
`endif

  // Next-state, shift-register, counter and flag update; READ has priority over SHIFT.
  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_cnt_nxt     = r_cnt;
    w_loaded_nxt  = r_loaded;
    w_drained_nxt = r_drained;
    if (i_read) begin
      w_sr_nxt      = w_image;
      w_cnt_nxt     = '0;
      w_drained_nxt = 1'b0;
      w_loaded_nxt  = 1'b1;
      w_state_nxt   = LOADED;
    end else if (i_shift) begin
      w_sr_nxt = {r_sr[DNA_WIDTH-2:0], i_din};
      if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      if (r_cnt == CNT_LAST) begin
        w_drained_nxt = 1'b1;
      end
      case (r_state)
        LOADED:   w_state_nxt = SHIFTING;
        SHIFTING: if (r_cnt == CNT_LAST) w_state_nxt = DRAINED_ST;
        default:  w_state_nxt = r_state;
      endcase
    end
`ifdef DNA_EMU_WRITE_EN
    // The shadow write never disturbs sr; READ in the same cycle sees the old shadow.
    w_shadow_nxt   = r_shadow;
    if (i_wr_valid && r_wr_ready) begin
      w_shadow_nxt = i_wr_data;
    end
    w_wr_ready_nxt = (w_state_nxt != SHIFTING);
`endif
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= EMPTY;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_loaded  <= 1'b0;
      r_drained <= 1'b0;
`ifdef DNA_EMU_WRITE_EN
      r_shadow   <= DNA_VALUE;
      r_wr_ready <= 1'b1;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_loaded  <= w_loaded_nxt;
      r_drained <= w_drained_nxt;
`ifdef DNA_EMU_WRITE_EN
      r_shadow   <= w_shadow_nxt;
      r_wr_ready <= w_wr_ready_nxt;
`endif
    end
  end

  assign o_dout      = r_sr[DNA_WIDTH-1];
  assign o_loaded    = r_loaded;
  assign o_drained   = r_drained;
  assign o_shift_cnt = r_cnt;
`ifdef DNA_EMU_WRITE_EN
  assign o_wr_ready  = r_wr_ready;
`endif

endmodule

// File: tb/tb_dna_port_emu.sv
// Scoreboard bench for dna_port_emu: a queue-based bit-stream model predicts
// outputs after every clock; a negedge monitor pops and compares.
// Build with +define+DNA_EMU_WRITE_EN to exercise the write port.
module tb_dna_port_emu;
  import dna_emu_pkg::*;

  localparam logic [DNA_WIDTH-1:0] DNA = 57'h03431c21141b01c;

  typedef struct {
    logic       dout;
    logic       loaded;
    logic       drained;
    logic [5:0] cnt;
    logic       wr_ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, rd, sh, din;
  logic       dout, loaded, drained;
  logic [5:0] shift_cnt;
`ifdef DNA_EMU_WRITE_EN
  logic                 wr_valid;
  logic                 wr_ready;
  logic [DNA_WIDTH-1:0] wr_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a FIFO of bits whose front is the bit on DOUT.
  bit                   m_sr[$];
  int                   m_cnt;
  bit                   m_loaded, m_drained;
  logic [DNA_WIDTH-1:0] m_shadow;
  exp_t                 sb[$];

  always #5 clk = ~clk;

  dna_port_emu #(.DNA_VALUE(DNA)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_read     (rd),
    .i_shift    (sh),
    .i_din      (din),
`ifdef DNA_EMU_WRITE_EN
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .i_wr_data  (wr_data),
`endif
    .o_dout     (dout),
    .o_loaded   (loaded),
    .o_drained  (drained),
    .o_shift_cnt(shift_cnt)
  );

  function automatic void m_fill(input logic [DNA_WIDTH-1:0] img);
    m_sr.delete();
    for (int i = DNA_WIDTH - 1; i >= 0; i--) m_sr.push_back(img[i]);
  endfunction

  function automatic void m_reset();
    m_fill('0);
    m_cnt     = 0;
    m_loaded  = 0;
    m_drained = 0;
    m_shadow  = DNA;
  endfunction

  // Writes are refused only while a loaded image is partway through being shifted out.
  function automatic bit m_ready();
    return !(m_loaded && m_cnt >= 1 && m_cnt < DNA_WIDTH);
  endfunction

  function automatic void check(input string name, input logic [5:0] act, input logic [5:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // One clock of stimulus; model is advanced after the edge and its prediction queued.
  task automatic cyc(input logic r, input logic s, input logic d, input logic rs,
                     input logic wv = 1'b0, input logic [DNA_WIDTH-1:0] wd = '0);
    bit   acc;
    exp_t e;
    rd = r; sh = s; din = d; rst = rs;
`ifdef DNA_EMU_WRITE_EN
    wr_valid = wv; wr_data = wd;
    acc = wv && m_ready();
`else
    acc = 1'b0;
`endif
    @(posedge clk);
    if (rs) begin
      m_reset();
    end else begin
      if (r) begin
        m_fill(m_shadow);
        m_cnt = 0; m_drained = 0; m_loaded = 1;
      end else if (s) begin
        void'(m_sr.pop_front());
        m_sr.push_back(d);
        if (m_cnt == DNA_WIDTH - 1) m_drained = 1;
        if (m_cnt < 63) m_cnt++;
      end
      if (acc) m_shadow = wd;
    end
    e.dout = m_sr[0]; e.loaded = m_loaded; e.drained = m_drained;
    e.cnt = 6'(m_cnt); e.wr_ready = m_ready();
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare every queued prediction against the settled outputs.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("dout",      6'(dout),    6'(e.dout));
      check("loaded",    6'(loaded),  6'(e.loaded));
      check("drained",   6'(drained), 6'(e.drained));
      check("shift_cnt", shift_cnt,   e.cnt);
`ifdef DNA_EMU_WRITE_EN
      check("wr_ready",  6'(wr_ready), 6'(e.wr_ready));
`endif
    end
  end

  initial begin
    logic [6:0] pat;
    logic [DNA_WIDTH-1:0] img;
    rst = 1; rd = 0; sh = 0; din = 0;
`ifdef DNA_EMU_WRITE_EN
    wr_valid = 0; wr_data = '0;
`endif
    m_reset();
    @(negedge clk);

    // Reset held for three clocks.
    repeat (3) cyc(0, 0, 0, 1);

    // Spec image constant: first DOUT bits are bit 56 then nibble 3.
    img = DNA;
    check("image_top_bit", 6'(img[56]), 6'd0);
    check("image_nibble", 6'(img[55:52]), 6'd3);

    // Full read-out of the image.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < DNA_WIDTH; i++) cyc(0, 1, $urandom_range(0, 1), 0);

    // Append a user pattern, keep shifting to see it re-emerge and the counter saturate.
    pat = 7'b0010010;
    for (int i = 6; i >= 0; i--) cyc(0, 1, pat[i], 0);
    for (int i = 0; i < 60; i++) cyc(0, 1, 1'b0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // READ and SHIFT together at count 20.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1'b1, 0);
    cyc(1, 1, 1'b1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1'b0, 0);

    // Reset mid-shift then clean restart.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 1, 1'b1, 0);
    cyc(0, 1, 1'b1, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < DNA_WIDTH; i++) cyc(0, 1, 1'b0, 0);

    // Shifting without any READ stays unloaded but counts.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1'b1, 0);

`ifdef DNA_EMU_WRITE_EN
    // Write accepted while LOADED, held off while SHIFTING, then used by next READ.
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1'b1, 57'h1_5555_5555_5555);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1'b0, 0, 1'b1, 57'h0AA_AAAA_AAAA_AAAA);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1'b1, 57'h0F0_F0F0_F0F0_F0F0);
    for (int i = 0; i < DNA_WIDTH; i++) cyc(0, 1, 1'b0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < DNA_WIDTH; i++) cyc(0, 1, 1'b0, 0);
`endif

    // Randomized traffic.
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      logic [DNA_WIDTH-1:0] wd;
      wd = {$urandom, $urandom};
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1),
          $urandom_range(0, 127) == 0, $urandom_range(0, 7) == 0, wd);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
